// File: rtl/bratcr_ctrl_if.sv
// rtl/bratcr_ctrl_if.sv - pipeline-side bundle for the branch RAT checkpoint controller
//
// Groups the ID allocation, branch resolution, retire and restore/status signals.
//   master : pipeline side (drives requests, resolutions, retires)
//   slave  : bratcr_ctrl (drives grants, stall, restore and status)
interface bratcr_ctrl_if #(
    parameter int NUM_ETY       = 4,
    parameter int ETY_CLOG      = 2,
    parameter int ISSUE_W       = 2,
    parameter int RETIRE_W      = 2,
    parameter int ROB_SIZE_CLOG = 6
);
    // ID-stage allocation
    logic [ISSUE_W-1:0]                         br_req_id;
    logic [ISSUE_W-1:0][ROB_SIZE_CLOG-1:0]      br_robid_id;
    logic [ISSUE_W-1:0]                         alloc_gnt;
    logic [ISSUE_W-1:0][ETY_CLOG-1:0]           alloc_ety;
    logic [NUM_ETY-1:0]                         ckpt_wr_en;
    logic                                       rename_stall;

    // branch resolution
    logic                                       res_val;
    logic                                       res_mispred;
    logic [ROB_SIZE_CLOG-1:0]                   res_robid;
    logic                                       res_rdy;

    // retire
    logic [RETIRE_W-1:0]                        ret_val;
    logic [RETIRE_W-1:0]                        ret_branch;
    logic [RETIRE_W-1:0][ROB_SIZE_CLOG-1:0]     ret_robid;

    // FRAT restore and status
    logic                                       restore_en;
    logic [ETY_CLOG-1:0]                        restore_ety;
    logic [NUM_ETY-1:0]                         ety_valid;
    logic                                       bratcr_full;
    logic                                       miss_err;

    modport master (
        output br_req_id, br_robid_id, res_val, res_mispred, res_robid,
               ret_val, ret_branch, ret_robid,
        input  alloc_gnt, alloc_ety, ckpt_wr_en, rename_stall, res_rdy,
               restore_en, restore_ety, ety_valid, bratcr_full, miss_err
    );

    modport slave (
        input  br_req_id, br_robid_id, res_val, res_mispred, res_robid,
               ret_val, ret_branch, ret_robid,
        output alloc_gnt, alloc_ety, ckpt_wr_en, rename_stall, res_rdy,
               restore_en, restore_ety, ety_valid, bratcr_full, miss_err
    );
endinterface

// File: rtl/bratcr_ctrl.sv
// rtl/bratcr_ctrl.sv - allocation, release and mispredict-restore control for the BRATCR checkpoint array
//
// Ports:
//   clk   : clock
//   rst   : asynchronous active-low reset
//   bus   : bratcr_ctrl_if.slave (allocation, resolution, retire, restore, status)
//   perf_stall_cnt / perf_restore_cnt : saturating event counters, present only
//                                       when BRATCR_PERF_CNT_EN is defined
//
// Entries form a circular queue in program order: head = oldest, tail = next free.
// A mispredict truncates the queue back to the matched entry, pulses restore_en
// for one cycle (RESTORE), then holds rename for DRAIN_CYC cycles (DRAIN).
module bratcr_ctrl #(
    parameter int NUM_ETY       = 4,
    parameter int ETY_CLOG      = 2,
    parameter int ISSUE_W       = 2,
    parameter int RETIRE_W      = 2,
    parameter int ROB_SIZE_CLOG = 6,
    parameter int DRAIN_CYC     = 2
) (
    input  logic              clk,
    input  logic              rst,
    bratcr_ctrl_if.slave      bus
`ifdef BRATCR_PERF_CNT_EN
    ,
    output logic [15:0]       perf_stall_cnt,
    output logic [15:0]       perf_restore_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RESTORE = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // state
    // ------------------------------------------------------------------
    state_t                     state_q, state_nxt;
    logic [3:0]                 drain_cnt_q, drain_cnt_nxt;
    logic [ETY_CLOG-1:0]        head_q, tail_q;
    logic [ETY_CLOG:0]          count_q;
    logic [NUM_ETY-1:0]         valid_q;
    logic [ROB_SIZE_CLOG-1:0]   robid_q [NUM_ETY];
    logic                       restore_en_q;
    logic [ETY_CLOG-1:0]        restore_ety_q;
    logic                       miss_err_q;

    // ------------------------------------------------------------------
    // combinational working signals
    // ------------------------------------------------------------------
    logic                               fsm_idle;
    logic                               res_rdy_c;
    logic                               hit;
    logic [ETY_CLOG-1:0]                match_idx;
    logic                               mis_req, mis_acc, mis_miss;
    logic                               alloc_en;
    logic [ETY_CLOG:0]                  free_cnt;
    logic [ETY_CLOG:0]                  ngnt;
    logic                               blocked;
    logic [ISSUE_W-1:0]                 gnt;
    logic [ISSUE_W-1:0][ETY_CLOG-1:0]   ety;
    logic [NUM_ETY-1:0]                 wr_en;
    logic [ETY_CLOG-1:0]                head_rel;
    logic [NUM_ETY-1:0]                 valid_rel;
    logic [ETY_CLOG-1:0]                n_trunc;
    logic [ETY_CLOG-1:0]                trunc_idx;
    logic [NUM_ETY-1:0]                 valid_nxt;
    logic [ETY_CLOG-1:0]                tail_nxt;
    logic [ETY_CLOG:0]                  count_nxt;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_nxt;
            drain_cnt_q <= drain_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt     = state_q;
        drain_cnt_nxt = drain_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (mis_acc) state_nxt = S_RESTORE;
            end
            S_RESTORE: begin
                state_nxt     = S_DRAIN;
                drain_cnt_nxt = 4'(DRAIN_CYC);
            end
            S_DRAIN: begin
                // an older branch may still mispredict while draining
                if (mis_acc) begin
                    state_nxt     = S_RESTORE;
                    drain_cnt_nxt = '0;
                end else if (drain_cnt_q <= 4'd1) begin
                    state_nxt     = S_IDLE;
                    drain_cnt_nxt = '0;
                end else begin
                    drain_cnt_nxt = drain_cnt_q - 4'd1;
                end
            end
            default: begin
                state_nxt     = S_IDLE;
                drain_cnt_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        fsm_idle  = (state_q == S_IDLE);
        res_rdy_c = (state_q != S_RESTORE);
    end

    // ------------------------------------------------------------------
    // mispredict match: robids of valid entries are unique
    // ------------------------------------------------------------------
    always_comb begin
        hit       = 1'b0;
        match_idx = '0;
        for (int e = 0; e < NUM_ETY; e++) begin
            if (!hit && valid_q[e] && (robid_q[e] == bus.res_robid)) begin
                hit       = 1'b1;
                match_idx = ETY_CLOG'(e);
            end
        end
        mis_req  = bus.res_val & bus.res_mispred & res_rdy_c;
        mis_acc  = mis_req & hit;
        mis_miss = mis_req & ~hit;
    end

    // ------------------------------------------------------------------
    // allocation: in-order across slots, a denied slot blocks all later ones
    // ------------------------------------------------------------------
    always_comb begin
        alloc_en = fsm_idle & ~mis_acc;
        free_cnt = (ETY_CLOG+1)'(NUM_ETY) - count_q;
        ngnt     = '0;
        blocked  = 1'b0;
        gnt      = '0;
        ety      = '0;
        wr_en    = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            ety[i] = tail_q + ngnt[ETY_CLOG-1:0];
            if (bus.br_req_id[i]) begin
                if (alloc_en && !blocked && (free_cnt > ngnt)) begin
                    gnt[i]        = 1'b1;
                    wr_en[ety[i]] = 1'b1;
                    ngnt          = ngnt + (ETY_CLOG+1)'(1);
                end else begin
                    blocked = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // release (oldest first), then truncation, then new allocations
    // ------------------------------------------------------------------
    always_comb begin
        head_rel  = head_q;
        valid_rel = valid_q;
        for (int p = 0; p < RETIRE_W; p++) begin
            if (bus.ret_val[p] && bus.ret_branch[p] && valid_rel[head_rel] &&
                (robid_q[head_rel] == bus.ret_robid[p])) begin
                valid_rel[head_rel] = 1'b0;
                head_rel            = head_rel + ETY_CLOG'(1);
            end
        end

        valid_nxt = valid_rel;
        n_trunc   = tail_q - match_idx;
        trunc_idx = '0;
        tail_nxt  = tail_q + ngnt[ETY_CLOG-1:0];
        if (mis_acc) begin
            // tail == match with a valid match means the queue was full:
            // everything from match onward (i.e. all entries) is discarded
            for (int k = 0; k < NUM_ETY; k++) begin
                trunc_idx = match_idx + ETY_CLOG'(k);
                if ((n_trunc == '0) || (ETY_CLOG'(k) < n_trunc))
                    valid_nxt[trunc_idx] = 1'b0;
            end
            tail_nxt = match_idx;
        end
        for (int i = 0; i < ISSUE_W; i++) begin
            if (gnt[i]) valid_nxt[ety[i]] = 1'b1;
        end

        // entries are contiguous, so occupancy is simply the valid popcount
        count_nxt = '0;
        for (int e = 0; e < NUM_ETY; e++) begin
            count_nxt = count_nxt + {{ETY_CLOG{1'b0}}, valid_nxt[e]};
        end
    end

    // ------------------------------------------------------------------
    // queue registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            valid_q       <= '0;
            restore_en_q  <= 1'b0;
            restore_ety_q <= '0;
            miss_err_q    <= 1'b0;
            for (int e = 0; e < NUM_ETY; e++) robid_q[e] <= '0;
        end else begin
            head_q       <= head_rel;
            tail_q       <= tail_nxt;
            count_q      <= count_nxt;
            valid_q      <= valid_nxt;
            restore_en_q <= mis_acc;
            if (mis_acc)  restore_ety_q <= match_idx;
            if (mis_miss) miss_err_q    <= 1'b1;
            for (int i = 0; i < ISSUE_W; i++) begin
                if (gnt[i]) robid_q[ety[i]] <= bus.br_robid_id[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // optional performance counters
    // ------------------------------------------------------------------
`ifdef BRATCR_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cnt   <= '0;
            perf_restore_cnt <= '0;
        end else begin
            // only stalls caused by lack of free entries, not restore/drain holds
            if (alloc_en && blocked && (perf_stall_cnt != 16'hFFFF))
                perf_stall_cnt <= perf_stall_cnt + 16'd1;
            if (restore_en_q && (perf_restore_cnt != 16'hFFFF))
                perf_restore_cnt <= perf_restore_cnt + 16'd1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // outputs
    // ------------------------------------------------------------------
    assign bus.alloc_gnt    = gnt;
    assign bus.alloc_ety    = ety;
    assign bus.ckpt_wr_en   = wr_en;
    assign bus.rename_stall = blocked | ~fsm_idle | mis_acc;
    assign bus.res_rdy      = res_rdy_c;
    assign bus.restore_en   = restore_en_q;
    assign bus.restore_ety  = restore_ety_q;
    assign bus.ety_valid    = valid_q;
    assign bus.bratcr_full  = (count_q == (ETY_CLOG+1)'(NUM_ETY));
    assign bus.miss_err     = miss_err_q;

endmodule

// File: tb/tb_bratcr_ctrl.sv
// tb/tb_bratcr_ctrl.sv - directed self-checking bench for bratcr_ctrl
module tb_bratcr_ctrl;
    localparam int NUM_ETY       = 4;
    localparam int ETY_CLOG      = 2;
    localparam int ISSUE_W       = 2;
    localparam int RETIRE_W      = 2;
    localparam int ROB_SIZE_CLOG = 6;
    localparam int DRAIN_CYC     = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    bratcr_ctrl_if #(
        .NUM_ETY(NUM_ETY), .ETY_CLOG(ETY_CLOG), .ISSUE_W(ISSUE_W),
        .RETIRE_W(RETIRE_W), .ROB_SIZE_CLOG(ROB_SIZE_CLOG)
    ) bif ();

`ifdef BRATCR_PERF_CNT_EN
    logic [15:0] perf_stall_cnt;
    logic [15:0] perf_restore_cnt;
`endif

    bratcr_ctrl #(
        .NUM_ETY(NUM_ETY), .ETY_CLOG(ETY_CLOG), .ISSUE_W(ISSUE_W),
        .RETIRE_W(RETIRE_W), .ROB_SIZE_CLOG(ROB_SIZE_CLOG), .DRAIN_CYC(DRAIN_CYC)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bif)
`ifdef BRATCR_PERF_CNT_EN
        ,
        .perf_stall_cnt   (perf_stall_cnt),
        .perf_restore_cnt (perf_restore_cnt)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bif.br_req_id   = '0;
        bif.br_robid_id = '0;
        bif.res_val     = 1'b0;
        bif.res_mispred = 1'b0;
        bif.res_robid   = '0;
        bif.ret_val     = '0;
        bif.ret_branch  = '0;
        bif.ret_robid   = '0;
    endtask

    initial begin
        idle_in();
        #2;
        // reset state
        chk("rst_gnt",     32'(bif.alloc_gnt),    32'h0);
        chk("rst_wr",      32'(bif.ckpt_wr_en),   32'h0);
        chk("rst_stall",   32'(bif.rename_stall), 32'h0);
        chk("rst_rdy",     32'(bif.res_rdy),      32'h1);
        chk("rst_restore", 32'(bif.restore_en),   32'h0);
        chk("rst_valid",   32'(bif.ety_valid),    32'h0);
        chk("rst_full",    32'(bif.bratcr_full),  32'h0);
        chk("rst_miss",    32'(bif.miss_err),     32'h0);
        step();
        step();
        rst = 1'b1;

        // two-slot allocation, robids 5 and 6
        bif.br_req_id   = 2'b11;
        bif.br_robid_id = {6'd6, 6'd5};
        #1;
        chk("a1_gnt",   32'(bif.alloc_gnt),    32'h3);
        chk("a1_ety",   32'(bif.alloc_ety),    32'h4);
        chk("a1_wr",    32'(bif.ckpt_wr_en),   32'h3);
        chk("a1_stall", 32'(bif.rename_stall), 32'h0);
        step();
        idle_in();
        #1;
        chk("a1_valid", 32'(bif.ety_valid),    32'h3);
        chk("a1_full",  32'(bif.bratcr_full),  32'h0);

        // third entry (robid 9)
        bif.br_req_id   = 2'b01;
        bif.br_robid_id = {6'd0, 6'd9};
        #1;
        chk("a2_gnt", 32'(bif.alloc_gnt),    32'h1);
        chk("a2_ety", 32'(bif.alloc_ety[0]), 32'h2);
        step();
        // only one free entry left: slot 0 granted, slot 1 denied
        bif.br_req_id   = 2'b11;
        bif.br_robid_id = {6'd13, 6'd12};
        #1;
        chk("a3_gnt",   32'(bif.alloc_gnt),    32'h1);
        chk("a3_stall", 32'(bif.rename_stall), 32'h1);
        chk("a3_wr",    32'(bif.ckpt_wr_en),   32'h8);
        step();
        idle_in();
        bif.br_req_id   = 2'b10;
        bif.br_robid_id = {6'd14, 6'd0};
        #1;
        chk("full_flag",  32'(bif.bratcr_full),  32'h1);
        chk("full_valid", 32'(bif.ety_valid),    32'hF);
        chk("full_gnt",   32'(bif.alloc_gnt),    32'h0);
        chk("full_stall", 32'(bif.rename_stall), 32'h1);
        idle_in();

        // mispredict on robid 9 (entry 2)
        bif.res_val     = 1'b1;
        bif.res_mispred = 1'b1;
        bif.res_robid   = 6'd9;
        #1;
        chk("mp_rdy",   32'(bif.res_rdy),      32'h1);
        chk("mp_stall", 32'(bif.rename_stall), 32'h1);
        step();
        idle_in();
        #1;
        chk("rs_en",    32'(bif.restore_en),   32'h1);
        chk("rs_ety",   32'(bif.restore_ety),  32'h2);
        chk("rs_valid", 32'(bif.ety_valid),    32'h3);
        chk("rs_rdy",   32'(bif.res_rdy),      32'h0);
        chk("rs_stall", 32'(bif.rename_stall), 32'h1);
        chk("rs_full",  32'(bif.bratcr_full),  32'h0);
        step();
        bif.br_req_id   = 2'b01;
        bif.br_robid_id = {6'd0, 6'd30};
        #1;
        chk("dr1_en",    32'(bif.restore_en),   32'h0);
        chk("dr1_rdy",   32'(bif.res_rdy),      32'h1);
        chk("dr1_stall", 32'(bif.rename_stall), 32'h1);
        chk("dr1_gnt",   32'(bif.alloc_gnt),    32'h0);
        step();
        idle_in();
        #1;
        chk("dr2_stall", 32'(bif.rename_stall), 32'h1);
        step();
        chk("dr_done",   32'(bif.rename_stall), 32'h0);

        // retire 5 and 6 together, then the discarded 9
        bif.ret_val    = 2'b11;
        bif.ret_branch = 2'b11;
        bif.ret_robid  = {6'd6, 6'd5};
        step();
        idle_in();
        #1;
        chk("ret2_valid", 32'(bif.ety_valid), 32'h0);
        bif.ret_val    = 2'b01;
        bif.ret_branch = 2'b01;
        bif.ret_robid  = {6'd0, 6'd9};
        step();
        idle_in();
        #1;
        chk("ret9_valid", 32'(bif.ety_valid), 32'h0);
        // tail was truncated back to entry 2
        bif.br_req_id   = 2'b01;
        bif.br_robid_id = {6'd0, 6'd20};
        #1;
        chk("a4_gnt", 32'(bif.alloc_gnt),    32'h1);
        chk("a4_ety", 32'(bif.alloc_ety[0]), 32'h2);
        step();
        idle_in();
        #1;
        chk("a4_valid", 32'(bif.ety_valid), 32'h4);

        // mispredict on unknown robid 40
        bif.res_val     = 1'b1;
        bif.res_mispred = 1'b1;
        bif.res_robid   = 6'd40;
        #1;
        chk("miss_stall", 32'(bif.rename_stall), 32'h0);
        step();
        idle_in();
        #1;
        chk("miss_err",  32'(bif.miss_err),   32'h1);
        chk("miss_en",   32'(bif.restore_en), 32'h0);
        chk("miss_rdy",  32'(bif.res_rdy),    32'h1);
        step();
        chk("miss_stky",  32'(bif.miss_err),     32'h1);
        chk("miss_valid", 32'(bif.ety_valid),    32'h4);
        chk("miss_idle",  32'(bif.rename_stall), 32'h0);

        // correct prediction resolves with no effect
        bif.res_val   = 1'b1;
        bif.res_robid = 6'd20;
        step();
        idle_in();
        #1;
        chk("okp_en",    32'(bif.restore_en), 32'h0);
        chk("okp_valid", 32'(bif.ety_valid),  32'h4);

        // reset asserted during DRAIN
        bif.res_val     = 1'b1;
        bif.res_mispred = 1'b1;
        bif.res_robid   = 6'd20;
        step();
        idle_in();
        step();
        chk("pre_rst_stall", 32'(bif.rename_stall), 32'h1);
        rst = 1'b0;
        #1;
        chk("ar_stall", 32'(bif.rename_stall), 32'h0);
        chk("ar_rdy",   32'(bif.res_rdy),      32'h1);
        chk("ar_valid", 32'(bif.ety_valid),    32'h0);
        chk("ar_miss",  32'(bif.miss_err),     32'h0);
        chk("ar_en",    32'(bif.restore_en),   32'h0);
        chk("ar_full",  32'(bif.bratcr_full),  32'h0);
        step();
        rst = 1'b1;
        bif.br_req_id   = 2'b11;
        bif.br_robid_id = {6'd2, 6'd1};
        #1;
        chk("post_gnt", 32'(bif.alloc_gnt), 32'h3);
        chk("post_ety", 32'(bif.alloc_ety), 32'h4);
        step();
        idle_in();
        #1;
        chk("post_valid", 32'(bif.ety_valid), 32'h3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
